aes_inv_cipher: RTL

Iterative AES-128 decryption core: accepts one 128-bit ciphertext block, runs the FIPS-197 inverse cipher at one round per clock and returns the plaintext block. Performs InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns internally. Round keys come from an external key store through an indexed, same-cycle lookup port. Pairs with the encryption datapath as the receive-side consumer of its ciphertext.

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_inv_round.sv | 28 ++
 rtl/aes_inv_cipher.sv | 124 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the forward and inverse datapaths.
//   state_t          128-bit AES state; byte 0 at [127:120], column-major
//                    (row r of column c = [127-32c-8r -: 8]).
//   NR               number of rounds for AES-128.
//   INV_SBOX         inverse S-box lookup table.
//   xtime / gf_mul   GF(2^8) arithmetic, reduction polynomial 0x11b.
//   inv_shift_rows, inv_sub_bytes, inv_mix_columns: whole-state transforms.
package aes_pkg;

  typedef logic [127:0] state_t;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by {02} in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = b[i] ? (acc ^ p) : acc;
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Row r rotates right by r bytes: s'[r][c] = s[r][(c-r) mod 4].
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
      end
    end
    return o;
  endfunction

  // Byte-wise inverse S-box substitution.
  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    end
    return o;
  endfunction

  // Per-column multiply by the {0e,0b,0d,09} circulant.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t     o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c - 8  -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse-cipher round.
//   st_in  [127:0]  current state
//   rk     [127:0]  round key for this round
//   last   1        final round: skip InvMixColumns
//   st_out [127:0]  InvMixColumns(InvSubBytes(InvShiftRows(st_in)) ^ rk),
//                   or without InvMixColumns when last is set
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_out
);

  state_t keyed_s;

  // Shared front half of every round, then the optional column mix.
  always_comb begin
    keyed_s = inv_sub_bytes(inv_shift_rows(st_in)) ^ rk;
    if (last) begin
      st_out = keyed_s;
    end else begin
      st_out = inv_mix_columns(keyed_s);
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, one round per clock.
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    ciphertext handshake, in_data [127:0]
//   rk_idx [3:0]         round-key index requested this cycle
//   rk_data [127:0]      round key for rk_idx, same-cycle lookup
//   out_valid/out_ready  plaintext handshake, out_data [127:0]
// in_ready and rk_idx depend on state only, so no input reaches an output
// combinationally. Accept-to-out_valid latency is 10 cycles.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state_r;
  state_t       st_r;
  logic [3:0]   round_r;
  logic         out_valid_r;
  logic [127:0] out_data_r;
  logic [127:0] round_out_s;
  logic         last_s;

  assign last_s = (state_r == FINAL);

  aes_inv_round u_round (
    .st_in  (st_r),
    .rk     (rk_data),
    .last   (last_s),
    .st_out (round_out_s)
  );

  // Ready and key-index decode from the state register only.
  always_comb begin
    in_ready = 1'b0;
    rk_idx   = NR;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = NR;
      end
      ROUND: begin
        rk_idx = round_r;
      end
      FINAL: begin
        rk_idx = 4'd0;
      end
      DONE: begin
        rk_idx = 4'd0;
      end
      default: begin
        in_ready = 1'b0;
        rk_idx   = NR;
      end
    endcase
  end

  // Round FSM, state register, counter and the registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      st_r        <= '0;
      round_r     <= 4'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 128'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            st_r    <= in_data ^ rk_data;
            round_r <= NR - 4'd1;
            state_r <= ROUND;
          end else begin
            state_r <= IDLE;
          end
        end
        ROUND: begin
          st_r    <= round_out_s;
          round_r <= round_r - 4'd1;
          // Round 1 is the last full round; the key-0 round follows.
          if (round_r == 4'd1) begin
            state_r <= FINAL;
          end else begin
            state_r <= ROUND;
          end
        end
        FINAL: begin
          out_data_r  <= round_out_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule
